// File: rtl/pipe_stage_ctrl.sv
// Stage reset/enable sequencer for the 5-stage MIPS pipeline: boot release, RAW stalls,
// branch flushes and data-memory waits. Define PIPE_CTRL_PERF_EN to add perf counters.
module pipe_stage_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_data_id,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic [4:0]  regw_addr_exe,
  input  logic        wb_wen_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_mem,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, MWAIT} state_e;

  localparam logic [2:0] BOOT_LAST = 3'(BOOT_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] boot_cnt_q, boot_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic [4:0] rs, rt;
  logic       rs_hit, rt_hit, flush, stall, wait_hit, hold, in_boot, run_rules;

  // Opcode/funct/immediate fields are not needed for hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

  always_comb begin
    rs       = inst_data_id[25:21];
    rt       = inst_data_id[20:16];
    rs_hit   = rs_used_id && (rs != 5'd0) &&
               ((wb_wen_exe && rs == regw_addr_exe) || (wb_wen_mem && rs == regw_addr_mem));
    rt_hit   = rt_used_id && (rt != 5'd0) &&
               ((wb_wen_exe && rt == regw_addr_exe) || (wb_wen_mem && rt == regw_addr_mem));
    flush    = is_branch_exe || is_branch_mem;
    // The squashed ID instruction is discarded anyway, so its hazard is moot.
    stall    = (rs_hit || rt_hit) && !flush;
    wait_hit = (wait_cnt_q == WAIT_LAST);
    in_boot  = !rst_n || (state_q == BOOT);
    hold     = (state_q == MWAIT) ? !(mem_ack || wait_hit) : (mem_req && !mem_ack);
    run_rules = !in_boot && !hold;
  end

  // Stage controls are combinational so hazard decisions act at the very next edge.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
    {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
    if (in_boot) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
    end else if (run_rules) begin
      {if_en, id_en, exe_en, mem_en, wb_en} = 5'b11111;
      if (stall) begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        exe_rst = 1'b1;
      end
      if (flush) exe_rst = 1'b1;
      if (is_branch_mem) id_rst = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      BOOT: begin
        if (boot_cnt_q != 3'd7) boot_cnt_d = boot_cnt_q + 3'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (hold) begin
          state_d    = MWAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MWAIT: begin
        if (wait_hit) mem_timeout_d = 1'b1;
        if (!hold) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      boot_cnt_q    <= 3'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_wait_q,  perf_wait_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, run_rules && stall};
    perf_flush_d = perf_flush_q + {31'd0, run_rules && flush};
    perf_wait_d  = perf_wait_q  + {31'd0, rst_n && (state_q == MWAIT)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_wait_q  <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized bench for pipe_stage_ctrl: a cycle-level rule model checked every negedge,
// plus directed sequences with hand-computed literal expectations.
module tb_pipe_stage_ctrl;
  localparam int BOOT = 4;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_data_id;
  logic        rs_used_id, rt_used_id;
  logic [4:0]  regw_addr_exe, regw_addr_mem;
  logic        wb_wen_exe, wb_wen_mem;
  logic        is_branch_exe, is_branch_mem;
  logic        mem_req, mem_ack;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_wait;
`endif

  pipe_stage_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .inst_data_id(inst_data_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
`endif
  );

  always #5 clk = ~clk;

  // {if_rst,id_rst,exe_rst,mem_rst,wb_rst, if_en,id_en,exe_en,mem_en,wb_en, mem_timeout}
  wire [10:0] outs = {if_rst, id_rst, exe_rst, mem_rst, wb_rst,
                      if_en, id_en, exe_en, mem_en, wb_en, mem_timeout};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: cycles spent booting since the last reset edge, length of the current memory wait.
  int m_boot = 0;
  int m_wn   = 0;
  bit m_wait = 0;
  bit m_to   = 0;

  function automatic bit raw_for(input logic used, input logic [4:0] r);
    return used && r != 0 && ((wb_wen_exe && r == regw_addr_exe) || (wb_wen_mem && r == regw_addr_mem));
  endfunction

  function automatic logic [10:0] model_outs();
    bit hold, flush, stall;
    if (!rst_n || m_boot < BOOT) return {10'b11111_00000, m_to};
    hold = m_wait ? !(mem_ack || m_wn >= TO) : (mem_req && !mem_ack);
    if (hold) return {10'b0, m_to};
    flush = is_branch_exe || is_branch_mem;
    stall = !flush && (raw_for(rs_used_id, inst_data_id[25:21]) ||
                       raw_for(rt_used_id, inst_data_id[20:16]));
    return {1'b0, is_branch_mem, flush || stall, 2'b00, !stall, !stall, 3'b111, m_to};
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_boot = 0; m_wait = 0; m_wn = 0; m_to = 0;
    end else if (m_boot < BOOT) begin
      m_boot++;
    end else if (m_wait) begin
      if (m_wn >= TO) m_to = 1;
      if (mem_ack || m_wn >= TO) begin
        m_wait = 0; m_wn = 0;
      end else begin
        m_wn++;
      end
    end else if (mem_req && !mem_ack) begin
      m_wait = 1; m_wn = 1;
    end
  endtask

  always @(negedge clk) begin
    check("model", outs, model_outs());
    model_step();
  end

  task automatic idle();
    inst_data_id = 32'd0; rs_used_id = 0; rt_used_id = 0;
    regw_addr_exe = 0; wb_wen_exe = 0; regw_addr_mem = 0; wb_wen_mem = 0;
    is_branch_exe = 0; is_branch_mem = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] exp);
    #1;
    check(name, outs, exp);
  endtask

  localparam logic [10:0] V_BOOT  = 11'b11111_00000_0;
  localparam logic [10:0] V_RUN   = 11'b00000_11111_0;
  localparam logic [10:0] V_STALL = 11'b00100_00111_0;
  localparam logic [10:0] V_HOLD  = 11'b00000_00000_0;

  initial begin
    idle();
    rst_n = 0;
    repeat (3) cyc();
    chk("in_reset", V_BOOT);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      chk("boot_hold", V_BOOT);
      cyc();
    end
    chk("boot_release", V_RUN);

    // RAW on rs: producer in EXE, then in MEM, then gone.
    inst_data_id = {6'd0, 5'd5, 5'd0, 16'd0}; rs_used_id = 1;
    wb_wen_exe = 1; regw_addr_exe = 5;
    chk("raw_exe", V_STALL);
    cyc();
    wb_wen_exe = 0; wb_wen_mem = 1; regw_addr_mem = 5;
    chk("raw_mem", V_STALL);
    cyc();
    wb_wen_mem = 0;
    chk("raw_clear", V_RUN);

    inst_data_id = 32'd0; wb_wen_exe = 1; regw_addr_exe = 0;
    chk("raw_r0", V_RUN);
    cyc();

    // Branch flush with a simultaneous RAW hit.
    inst_data_id = {6'd0, 5'd5, 5'd0, 16'd0}; regw_addr_exe = 5; is_branch_exe = 1;
    chk("br_exe", 11'b00100_11111_0);
    cyc();
    is_branch_exe = 0; is_branch_mem = 1;
    chk("br_mem", 11'b01100_11111_0);
    cyc();
    idle();
    chk("br_done", V_RUN);

    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      chk("mwait", V_HOLD);
      cyc();
    end
    mem_ack = 1;
    chk("mack", V_RUN);
    cyc();
    idle();

    mem_ack = 0; mem_req = 1;
    for (int i = 0; i < TO; i++) begin
      chk("to_wait", V_HOLD);
      cyc();
    end
    chk("to_release", V_RUN);
    mem_req = 0;
    cyc();
    chk("to_sticky", 11'b00000_11111_1);
    cyc();
    chk("to_sticky2", 11'b00000_11111_1);

    mem_req = 1;
    cyc();
    rst_n = 0;
    chk("rst_mid_wait", 11'b11111_00000_1);
    cyc();
    rst_n = 1; idle();
    chk("rst_clears", V_BOOT);

    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst_n         = ($urandom_range(0, 299) != 0);
      inst_data_id  = {6'd0, 3'd0, 2'($urandom_range(0, 3)), 3'd0, 2'($urandom_range(0, 3)), 16'($urandom)};
      rs_used_id    = 1'($urandom);
      rt_used_id    = 1'($urandom);
      regw_addr_exe = 5'($urandom_range(0, 3));
      regw_addr_mem = 5'($urandom_range(0, 3));
      wb_wen_exe    = 1'($urandom);
      wb_wen_mem    = 1'($urandom);
      is_branch_exe = ($urandom_range(0, 7) == 0);
      is_branch_mem = ($urandom_range(0, 7) == 0);
      mem_req       = ($urandom_range(0, 3) == 0);
      mem_ack       = ($urandom_range(0, 2) == 0);
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
